intpol_ctrl_fsm: RTL and testbench

Parametrised control FSM for the order-2 streaming interpolator. It supports N_CH time-multiplexed channels, a runtime interpolation factor, a configurable priming depth, a bypass pass-through mode, and a graceful stop request. It sits between the input FIFO, the coefficient, accumulator and multiplier datapath, and the output FIFO. It issues all read, write, load and accumulate strobes and exposes the step and channel indices to the datapath.

---
 rtl/intpol_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_intpol_ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intpol_ctrl_fsm.sv
// Control FSM for the order-2 streaming interpolator: sequences priming, coefficient
// calculation, per-step accumulate/emit, per-frame refetch and a FIFO-to-FIFO bypass.
module intpol_ctrl_fsm #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PRIME = 3,
    parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             bypass,
    input  logic [CNT_W-1:0] factor,
    input  logic             stop,
    input  logic             in_empty,
    input  logic             out_afull,
    output logic             busy,
    output logic             rd_en,
    output logic             wr_en,
    output logic             coef_calc,
    output logic             ld_acc,
    output logic             acc_en,
    output logic             sel_mult,
    output logic [CH_W-1:0]  ch,
    output logic [CNT_W-1:0] step,
    output logic             frame_done,
    output logic             stall_empty,
    output logic             stall_afull,
    output logic             clear
);

    localparam int unsigned PRIME_TOT = PRIME * N_CH;
    localparam int unsigned PC_W      = (PRIME_TOT > 1) ? $clog2(PRIME_TOT) : 1;
    localparam int unsigned FC_W      = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [PC_W-1:0] PRIME_LAST = PC_W'(PRIME_TOT - 1);
    localparam logic [FC_W-1:0] FETCH_LAST = FC_W'(N_CH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_PRIME,
        S_COEF,
        S_LOAD,
        S_EMIT,
        S_DONE,
        S_FETCH,
        S_BYPASS
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] l_reg;
    logic             byp_reg;
    logic             stop_req;
    logic [PC_W-1:0]  prime_cnt, prime_nx;
    logic [FC_W-1:0]  fetch_cnt, fetch_nx;
    logic [CNT_W-1:0] step_nx;
    logic [CH_W-1:0]  ch_nx;
    logic [CH_W-1:0]  ch_wrap;
    logic             xfer;

    assign ch_wrap = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
    assign xfer    = !in_empty && !out_afull;

    // State and counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            prime_cnt <= '0;
            fetch_cnt <= '0;
            step      <= '0;
            ch        <= '0;
        end else begin
            state     <= state_nx;
            prime_cnt <= prime_nx;
            fetch_cnt <= fetch_nx;
            step      <= step_nx;
            ch        <= ch_nx;
        end
    end

    // Configuration captured on every start cycle; stop request held until the frame ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l_reg    <= CNT_W'(1);
            byp_reg  <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            if (start) begin
                l_reg   <= (factor == '0) ? CNT_W'(1) : factor;
                byp_reg <= bypass;
            end
            if (state == S_IDLE || state == S_CLEAR) begin
                stop_req <= 1'b0;
            end else if (stop) begin
                stop_req <= 1'b1;
            end
        end
    end

    // Next-state, counter updates and strobe decode
    always_comb begin
        state_nx    = state;
        prime_nx    = prime_cnt;
        fetch_nx    = fetch_cnt;
        step_nx     = step;
        ch_nx       = ch;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        coef_calc   = 1'b0;
        ld_acc      = 1'b0;
        acc_en      = 1'b0;
        sel_mult    = 1'b0;
        frame_done  = 1'b0;
        stall_empty = 1'b0;
        stall_afull = 1'b0;
        clear       = start || (state == S_CLEAR);
        busy        = (state != S_IDLE) && (state != S_CLEAR);

        if (start && state != S_IDLE) begin
            // Restart wins over everything and suppresses every strobe this cycle
            state_nx = S_CLEAR;
            prime_nx = '0;
            fetch_nx = '0;
            step_nx  = '0;
            ch_nx    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    prime_nx = '0;
                    fetch_nx = '0;
                    step_nx  = '0;
                    ch_nx    = '0;
                    if (start) begin
                        state_nx = bypass ? S_BYPASS : S_PRIME;
                    end
                end
                S_CLEAR: begin
                    prime_nx = '0;
                    fetch_nx = '0;
                    step_nx  = '0;
                    ch_nx    = '0;
                    state_nx = byp_reg ? S_BYPASS : S_PRIME;
                end
                S_PRIME: begin
                    rd_en       = !in_empty;
                    stall_empty = in_empty;
                    if (!in_empty) begin
                        ch_nx = ch_wrap;
                        if (prime_cnt == PRIME_LAST) begin
                            prime_nx = '0;
                            ch_nx    = '0;
                            state_nx = S_COEF;
                        end else begin
                            prime_nx = prime_cnt + PC_W'(1);
                        end
                    end
                end
                S_COEF: begin
                    coef_calc = 1'b1;
                    state_nx  = S_LOAD;
                end
                S_LOAD: begin
                    ld_acc   = 1'b1;
                    state_nx = S_EMIT;
                end
                S_EMIT: begin
                    sel_mult = 1'b1;
                    if (out_afull) begin
                        stall_afull = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (step != l_reg - CNT_W'(1)) begin
                            acc_en   = 1'b1;
                            step_nx  = step + CNT_W'(1);
                            state_nx = S_LOAD;
                        end else begin
                            step_nx = '0;
                            if (ch != CH_LAST) begin
                                ch_nx    = ch + CH_W'(1);
                                state_nx = S_COEF;
                            end else begin
                                ch_nx    = '0;
                                state_nx = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    frame_done = 1'b1;
                    state_nx   = (stop_req || stop) ? S_IDLE : S_FETCH;
                end
                S_FETCH: begin
                    rd_en       = !in_empty;
                    stall_empty = in_empty;
                    if (!in_empty) begin
                        ch_nx = ch_wrap;
                        if (fetch_cnt == FETCH_LAST) begin
                            fetch_nx = '0;
                            ch_nx    = '0;
                            state_nx = S_COEF;
                        end else begin
                            fetch_nx = fetch_cnt + FC_W'(1);
                        end
                    end
                end
                S_BYPASS: begin
                    rd_en       = xfer;
                    wr_en       = xfer;
                    stall_empty = in_empty;
                    stall_afull = out_afull;
                    if (stop) begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intpol_ctrl_fsm.sv
// Bench for intpol_ctrl_fsm: randomized FIFO stalls checked cycle by cycle against
// a schedule-of-operations reference model, plus directed timing and restart checks.
module tb_intpol_ctrl_fsm;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PRIME = 3;
    localparam int unsigned CH_W  = 1;
    localparam int unsigned SB    = CH_W + CNT_W;
    localparam int unsigned VW    = 11 + SB;

    logic             clk = 1'b0;
    logic             rstn, start, bypass, stop, in_empty, out_afull;
    logic [CNT_W-1:0] factor;
    logic             busy, rd_en, wr_en, coef_calc, ld_acc, acc_en, sel_mult;
    logic             frame_done, stall_empty, stall_afull, clear;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] step;

    intpol_ctrl_fsm #(.N_CH(N_CH), .CNT_W(CNT_W), .PRIME(PRIME), .CH_W(CH_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .bypass(bypass), .factor(factor),
        .stop(stop), .in_empty(in_empty), .out_afull(out_afull), .busy(busy),
        .rd_en(rd_en), .wr_en(wr_en), .coef_calc(coef_calc), .ld_acc(ld_acc),
        .acc_en(acc_en), .sel_mult(sel_mult), .ch(ch), .step(step),
        .frame_done(frame_done), .stall_empty(stall_empty), .stall_afull(stall_afull),
        .clear(clear)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_SCHED, M_BYP} mode_e;
    typedef enum int {OP_READ, OP_COEF, OP_LOAD, OP_EMIT, OP_DONE} op_kind_e;
    typedef struct {
        op_kind_e kind;
        int       ch;
        int       step;
        bit       last;
    } op_t;

    op_t   sched[$];
    mode_e mode = M_IDLE;
    int    model_l = 1;
    bit    stop_pend = 0;
    int    checks = 0, failures = 0, cyc = 0;
    int    n_wr = 0, n_acc = 0, n_coef = 0, n_saf = 0;
    int    done_cyc[$];

    function automatic void push_op(op_kind_e k, int c, int s, bit l);
        op_t op;
        op.kind = k; op.ch = c; op.step = s; op.last = l;
        sched.push_back(op);
    endfunction

    // One frame as an ordered list of operations: reads, then per channel COEF + L x (LOAD, EMIT), then DONE
    function automatic void push_frame(int reads_per_ch);
        for (int i = 0; i < reads_per_ch * int'(N_CH); i++) push_op(OP_READ, i % int'(N_CH), 0, 0);
        for (int c = 0; c < int'(N_CH); c++) begin
            push_op(OP_COEF, c, 0, 0);
            for (int s = 0; s < model_l; s++) begin
                push_op(OP_LOAD, c, s, 0);
                push_op(OP_EMIT, c, s, s == model_l - 1);
            end
        end
        push_op(OP_DONE, 0, 0, 0);
    endfunction

    function automatic logic [VW-1:0] observed();
        return {busy, rd_en, wr_en, coef_calc, ld_acc, acc_en, sel_mult, frame_done,
                stall_empty, stall_afull, clear, ch, step};
    endfunction

    task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s timeout observed=expired expected=event", tag);
    endtask

    function automatic void tally();
        n_wr   += int'(wr_en);
        n_acc  += int'(acc_en);
        n_coef += int'(coef_calc);
        n_saf  += int'(stall_afull);
        if (frame_done) done_cyc.push_back(cyc);
    endfunction

    // One clock with start low: compare every output with the model, then advance the model
    task automatic run_cycle(input bit ie, input bit af, input bit stp);
        bit e_busy, e_rd, e_wr, e_coef, e_ld, e_acc, e_sel, e_fd, e_se, e_sa, adv;
        int e_ch, e_step;
        op_t op;
        @(negedge clk);
        start = 1'b0; stop = stp; in_empty = ie; out_afull = af;
        factor = CNT_W'($urandom); bypass = 1'($urandom);
        #1;
        cyc++;
        {e_busy, e_rd, e_wr, e_coef, e_ld, e_acc, e_sel, e_fd, e_se, e_sa, adv} = '0;
        e_ch = 0; e_step = 0;
        if (mode == M_BYP) begin
            e_busy = 1; e_rd = !ie && !af; e_wr = !ie && !af; e_se = ie; e_sa = af;
            if (stp) mode = M_IDLE;
        end else if (mode == M_SCHED) begin
            e_busy = 1;
            op = sched[0];
            e_ch = op.ch; e_step = op.step;
            if (stp) stop_pend = 1;
            case (op.kind)
                OP_READ: begin e_rd = !ie; e_se = ie; adv = !ie; end
                OP_COEF: begin e_coef = 1; adv = 1; end
                OP_LOAD: begin e_ld = 1; adv = 1; end
                OP_EMIT: begin
                    e_sel = 1; e_sa = af; e_wr = !af; e_acc = !af && !op.last; adv = !af;
                end
                default: begin e_fd = 1; adv = 1; end
            endcase
            if (adv) begin
                void'(sched.pop_front());
                if (op.kind == OP_DONE) begin
                    if (stop_pend) begin
                        mode = M_IDLE; stop_pend = 0;
                    end else begin
                        push_frame(1);
                    end
                end
            end
        end
        check_vec("cycle", observed(),
                  {e_busy, e_rd, e_wr, e_coef, e_ld, e_acc, e_sel, e_fd, e_se, e_sa, 1'b0,
                   CH_W'(e_ch), CNT_W'(e_step)});
        tally();
    endtask

    // Hold start for n cycles (1 when idle), check the clear window and re-arm the model
    task automatic do_start(input int n_req, input int fac, input bit byp);
        int n;
        logic [VW-1:0] mask, exp;
        bit from_idle;
        from_idle = (mode == M_IDLE);
        n = from_idle ? 1 : n_req;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b1; stop = 1'b0; factor = CNT_W'(fac); bypass = byp;
            in_empty = 1'($urandom); out_afull = 1'($urandom);
            #1;
            cyc++;
            mask = '1;
            exp = '0;
            exp[SB] = 1'b1;
            if (i == 0 && !from_idle) begin
                exp[VW-1] = 1'b1;
                mask[SB+2:SB+1] = 2'b00;
                mask[SB-1:0] = '0;
            end
            check_vec("start", observed() & mask, exp & mask);
            tally();
        end
        if (!from_idle) begin
            @(negedge clk);
            start = 1'b0; factor = CNT_W'($urandom); bypass = 1'($urandom);
            #1;
            cyc++;
            exp = '0;
            exp[SB] = 1'b1;
            check_vec("clear_tail", observed(), exp);
            tally();
        end
        model_l = (fac == 0) ? 1 : fac;
        sched.delete();
        stop_pend = 0;
        mode = byp ? M_BYP : M_SCHED;
        if (!byp) push_frame(int'(PRIME));
    endtask

    task automatic clr_tally();
        n_wr = 0; n_acc = 0; n_coef = 0; n_saf = 0;
        done_cyc.delete();
    endtask

    initial begin
        int base, budget, k, n_done_at_stop;
        logic [VW-1:0] exp;
        bit hit;

        // Reset: everything 0, clear follows start
        rstn = 1'b0; start = 1'b0; bypass = 1'b0; stop = 1'b0;
        in_empty = 1'b0; out_afull = 1'b0; factor = '0;
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset", observed(), '0);
        start = 1'b1;
        #1;
        exp = '0; exp[SB] = 1'b1;
        check_vec("reset_clear", observed(), exp);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        run_cycle(0, 0, 0);

        // L=4, no stalls: 6 reads, 8 writes, 6 accumulates, frame_done at cycle 25, then 21-cycle frames
        do_start(1, 4, 0);
        clr_tally();
        base = cyc;
        repeat (25) run_cycle(0, 0, 0);
        check_int("l4_wr", n_wr, 8);
        check_int("l4_acc", n_acc, 6);
        check_int("l4_coef", n_coef, 2);
        check_int("l4_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] - base : -1, 25);
        repeat (21) run_cycle(0, 0, 0);
        check_int("l4_frame_period", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, 21);

        // Restart for 3 cycles mid-EMIT, then out_afull held 5 cycles at step 2 of channel 0
        budget = 50;
        while (budget > 0 && sched[0].kind != OP_EMIT) begin run_cycle(0, 0, 0); budget--; end
        if (budget == 0) timeout("seek_emit");
        do_start(3, 4, 0);
        clr_tally();
        base = cyc;
        k = 0;
        budget = 80;
        while (budget > 0 && done_cyc.size() == 0) begin
            hit = (mode == M_SCHED) && sched[0].kind == OP_EMIT && sched[0].step == 2
                  && sched[0].ch == 0 && k < 5;
            if (hit) k++;
            run_cycle(0, hit, 0);
            budget--;
        end
        if (budget == 0) timeout("stall_frame");
        check_int("stall_afull_cycles", n_saf, 5);
        check_int("stall_wr", n_wr, 8);
        check_int("stall_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] - base : -1, 30);

        // factor=0 behaves as L=1: first frame 13 cycles, then one frame_done every 9
        do_start(2, 0, 0);
        clr_tally();
        base = cyc;
        budget = 60;
        while (budget > 0 && done_cyc.size() < 3) begin run_cycle(0, 0, 0); budget--; end
        if (budget == 0) timeout("l1_frames");
        check_int("l1_acc", n_acc, 0);
        check_int("l1_wr", n_wr, 6);
        check_int("l1_first_done", (done_cyc.size() > 0) ? done_cyc[0] - base : -1, 13);
        check_int("l1_period", (done_cyc.size() > 2) ? done_cyc[2] - done_cyc[1] : -1, 9);

        // Randomized FIFO stalls, factors, restarts and occasional stop requests
        for (int r = 0; r < 8; r++) begin
            do_start(1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), 0);
            for (int i = 0; i < 150; i++) begin
                if (mode == M_IDLE) break;
                run_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 99) < 2);
            end
        end

        // Bypass: in_empty toggles, then random out_afull; stop returns to IDLE
        do_start(2, 3, 1);
        clr_tally();
        for (int i = 0; i < 10; i++) run_cycle(i[0], 0, 0);
        check_int("byp_wr", n_wr, 5);
        for (int i = 0; i < 10; i++) run_cycle(i[0], 1'($urandom), 0);
        run_cycle(0, 0, 1);
        run_cycle(0, 0, 0);
        check_int("byp_idle", int'(busy), 0);

        // Stop mid-frame completes that frame only
        do_start(1, 2, 0);
        budget = 50;
        while (budget > 0 && sched[0].kind != OP_EMIT) begin run_cycle(0, 0, 0); budget--; end
        if (budget == 0) timeout("seek_emit_stop");
        clr_tally();
        run_cycle(0, 0, 1);
        budget = 60;
        while (budget > 0 && mode != M_IDLE) begin run_cycle(0, 0, 0); budget--; end
        if (budget == 0) timeout("stop_frame");
        n_done_at_stop = done_cyc.size();
        repeat (3) run_cycle(0, 0, 0);
        check_int("stop_frames", done_cyc.size(), 1);
        check_int("stop_no_more", done_cyc.size() - n_done_at_stop, 0);

        // Asynchronous reset in the middle of FETCH
        do_start(1, 3, 0);
        clr_tally();
        budget = 60;
        while (budget > 0 && done_cyc.size() == 0) begin run_cycle(0, 0, 0); budget--; end
        if (budget == 0) timeout("seek_fetch");
        run_cycle(0, 0, 0);
        check_int("in_fetch", int'(rd_en), 1);
        #1 rstn = 1'b0;
        #1;
        check_vec("async_reset", observed(), '0);
        mode = M_IDLE; sched.delete(); stop_pend = 0;
        @(negedge clk);
        rstn = 1'b1;
        run_cycle(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
